sr64_deser: RTL and testbench
=============================

Name: sr64_deser

Overview:
- Receive-side counterpart of the 64-bit parallel-load shift register.
- Takes the serial bit stream that register emits and rebuilds N-bit words.
- Frames start with a start pulse; each bit is qualified by a strobe.
- A completed word is held in an output buffer under a valid/ready handshake, so the next frame can shift in while the consumer drains.

Parameters:
- N, 64, word width in bits; legal range 2..64.
- MSB_FIRST, 0, 0 = first received bit lands in bit 0 (matches transmitter right-shift); 1 = first bit lands in bit N-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  frame start pulse; aborts any partial frame.
- serin  input  1  serial data bit.
- ser_valid  input  1  serin qualifier; one bit sampled per cycle while high in SHIFT.
- dout_ready  input  1  consumer accepts Data_out this cycle.
- clr_ovr  input  1  clears the overrun flag.
- Data_out  output  N  assembled word, held while dout_valid.
- dout_valid  output  1  Data_out holds an unconsumed word.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, active-high) forces: Data_out=0, dout_valid=0, busy=0, overrun=0, shift reg=0, bit count=0, state=IDLE.
- States and transitions:
  - IDLE: start=1 -> SHIFT, count:=0, shift reg:=0.
  - SHIFT: start=1 -> restart (count:=0, shift reg:=0, stay in SHIFT).
  - SHIFT: ser_valid=1 and start=0 -> sample serin, count:=count+1.
  - SHIFT: sampling the Nth bit -> IDLE.
- Start wins over ser_valid in the same cycle; that cycle's serin is discarded.
- Bit placement:
  - MSB_FIRST=0: shift right; new bit enters bit N-1; after N bits, first bit sits at bit 0.
  - MSB_FIRST=1: shift left; new bit enters bit 0.
- Count width is clog2(N+1); the count never exceeds N.
- Completion, on the edge that samples the Nth bit:
  - If dout_valid=0, or dout_ready=1 in that cycle: Data_out := full word including that bit; dout_valid=1 after the same edge (zero extra latency).
  - Otherwise: the word is dropped, Data_out keeps the old word, overrun := 1.
- Handshake:
  - A transfer occurs on a cycle with dout_valid & dout_ready.
  - dout_valid falls on the next edge unless a new word completes in that same cycle; if one does, Data_out updates and dout_valid stays 1.
  - Data_out is stable while dout_valid=1 and no transfer occurs.
- overrun: sticky until clr_ovr=1. If set and clear occur in the same cycle, set wins.
- ser_valid in IDLE is ignored.
- dout_ready while dout_valid=0 has no effect.
- busy = (state==SHIFT).
- Reset mid-frame: partial word is lost immediately, no output pulse.
- Reset while dout_valid=1: the pending word is lost.

Decomposition:
- Shared package/header sr_defs:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - default width constant SR_WIDTH=64.
  - count-width function.
- One natural sub-module: sr_bit_counter.
  - Parameterised by N; clear/enable inputs; done output on the Nth increment.
  - Reused by the transmit-side frame counter.

Test Plan:
- Reset: reset=1 at t=0, released after 10 ns -> all outputs 0, busy=0.
- LSB-first frame: start, then 64 strobed bits of 64'd4294967296 (bit 32 only =1), with dout_ready=0.
  - Edge of the 64th bit: Data_out=64'h0000_0001_0000_0000, dout_valid=1.
  - Next cycle: busy=0.
- Back-to-back with drain: second frame 64'hFFFF_FFFF_FFFF_FFFF; dout_ready=1 in the completion cycle.
  - Data_out switches to all-ones, dout_valid stays 1, overrun=0.
- Overrun: a third frame 64'hA5A5_A5A5_A5A5_A5A5 completes with dout_valid=1 and dout_ready=0.
  - Data_out keeps its previous value; overrun=1.
  - Data_out and overrun hold across 5 idle cycles.
  - clr_ovr pulse clears overrun.
- Abort and restart: start, 20 bits of 1, start again (same cycle as ser_valid=1), then 64 bits of 64'h1.
  - Output is exactly 64'h1; completion occurs 64 strobes after the second start.
- Mid-frame reset and gapped strobes: 30 bits shifted, reset pulse.
  - All outputs 0; no dout_valid pulse.
  - A following frame with ser_valid low on alternate cycles still assembles 64'h8000_0000_0000_0001 correctly.

Source files
------------

// File: rtl/sr64_deser_pkg.sv
// sr64_deser_pkg
// Shared definitions for the serial deserializer and its bit counter:
// the FSM state encoding, the default word width, and the count-width helper.
package sr64_deser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int SR_WIDTH = 64;

  // The count must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr64_deser_if.sv
// sr64_deser_if
// Bundles the frame input, the output-word handshake and the status signals.
//   slave  : the deserializer (inputs start/serin/ser_valid/dout_ready/clr_ovr,
//            outputs Data_out/dout_valid/busy/overrun/dbg_state)
//   master : the producer/consumer side (opposite directions)
// Handshake: a word moves on every clock edge where dout_valid and dout_ready
// are both 1; Data_out is held stable while dout_valid=1 and no transfer occurs,
// and dout_ready has no effect while dout_valid=0.
interface sr64_deser_if
  import sr64_deser_pkg::*;
#(
  parameter int N = SR_WIDTH
);

  logic         start;
  logic         serin;
  logic         ser_valid;
  logic         dout_ready;
  logic         clr_ovr;
  logic [N-1:0] Data_out;
  logic         dout_valid;
  logic         busy;
  logic         overrun;
  state_t       dbg_state;

  modport slave (
    input  start, serin, ser_valid, dout_ready, clr_ovr,
    output Data_out, dout_valid, busy, overrun, dbg_state
  );

  modport master (
    output start, serin, ser_valid, dout_ready, clr_ovr,
    input  Data_out, dout_valid, busy, overrun, dbg_state
  );

endinterface

// File: rtl/sr64_deser_bit_counter.sv
// sr64_deser_bit_counter
// Counts strobed bits of a frame, 0..N.
//   clock, reset : rising-edge clock, async active-high reset
//   i_clr        : restart the count at 0 (has priority over i_en)
//   i_en         : one bit accepted this cycle
//   o_done       : this cycle's increment is the Nth one
module sr64_deser_bit_counter
  import sr64_deser_pkg::*;
#(
  parameter  int N  = SR_WIDTH,
  localparam int CW = cnt_width(N)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(N - 1));
  assign o_done = i_en & ~i_clr & w_last;

  // After the Nth bit the count parks at N until the next clear, so it
  // never exceeds N.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sr64_deser.sv
// sr64_deser
// Rebuilds N-bit words from a strobed serial stream. A start pulse begins
// (or restarts) a frame; each ser_valid cycle shifts in one bit. The finished
// word goes to a one-entry output buffer with a valid/ready handshake, so the
// next frame can shift in while the consumer drains.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : sr64_deser_if slave modport (see interface for signals)
// MSB_FIRST=0: first received bit ends in bit 0; MSB_FIRST=1: in bit N-1.
module sr64_deser
  import sr64_deser_pkg::*;
#(
  parameter int N         = SR_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  sr64_deser_if.slave     bus
);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_shift;
  logic [N-1:0] w_shift_next;
  logic [N-1:0] r_data;
  logic         r_valid;
  logic         r_ovr;
  logic         w_sample;
  logic         w_done;
  logic         w_accept;

  // Start wins over a strobe in the same cycle; that serin is discarded.
  assign w_sample = (r_state == ST_SHIFT) && bus.ser_valid && !bus.start;

  sr64_deser_bit_counter #(.N(N)) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (bus.start),
    .i_en   (w_sample),
    .o_done (w_done)
  );

  // The buffer can take the new word if it is empty or being drained in
  // this very cycle; otherwise the word is dropped and flagged.
  assign w_accept = w_done && (!r_valid || bus.dout_ready);

  always_comb begin
    w_shift_next = r_shift;
    if (bus.start) begin
      w_shift_next = '0;
    end else if (w_sample) begin
      if (MSB_FIRST) begin
        w_shift_next = {r_shift[N-2:0], bus.serin};
      end else begin
        w_shift_next = {bus.serin, r_shift[N-1:1]};
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.start)   w_state_next = ST_SHIFT;
        else if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;

      // Completed word bypasses the shift register so it is visible right
      // after the edge that samples the last bit.
      if (w_accept) begin
        r_data  <= w_shift_next;
        r_valid <= 1'b1;
      end else if (bus.dout_ready) begin
        r_valid <= 1'b0;
      end

      // Setting beats clearing when both happen in one cycle.
      if (w_done && !w_accept) begin
        r_ovr <= 1'b1;
      end else if (bus.clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign bus.Data_out   = r_data;
  assign bus.dout_valid = r_valid;
  assign bus.busy       = (r_state == ST_SHIFT);
  assign bus.overrun    = r_ovr;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_sr64_deser.sv
// tb_sr64_deser
// Directed frames into sr64_deser (N=64, LSB first). Frames that should
// reach the output buffer push their word into exp_q; a monitor on the
// falling edge pops and compares each newly presented word.
module tb_sr64_deser;
  import sr64_deser_pkg::*;

  localparam int N = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];

  logic mon_prev_valid = 1'b0;
  logic mon_prev_ready = 1'b0;

  sr64_deser_if #(.N(N)) bus ();

  sr64_deser #(.N(N), .MSB_FIRST(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_start(input logic sv, input logic si);
    bus.start     = 1'b1;
    bus.ser_valid = sv;
    bus.serin     = si;
    tick();
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
  endtask

  // Sends bits 0..nbits-1 of w, LSB first; optional idle gap before each bit;
  // dout_ready is driven to ready_last only during the final bit's cycle.
  task automatic send_bits(input logic [N-1:0] w, input int nbits,
                           input bit gapped, input logic ready_last);
    for (int i = 0; i < nbits; i++) begin
      if (gapped) begin
        bus.ser_valid = 1'b0;
        tick();
      end
      bus.ser_valid  = 1'b1;
      bus.serin      = w[i];
      bus.dout_ready = (i == nbits - 1) ? ready_last : 1'b0;
      tick();
    end
    bus.ser_valid  = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic drain();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // A new word is presented when dout_valid is high and either was low last
  // cycle or a transfer happened last cycle.
  always @(negedge clock) begin
    if (reset) begin
      mon_prev_valid = 1'b0;
      mon_prev_ready = 1'b0;
    end else begin
      if (bus.dout_valid && (!mon_prev_valid || mon_prev_ready)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %h expected no word", bus.Data_out);
        end else begin
          check("word", bus.Data_out, exp_q.pop_front());
        end
      end
      mon_prev_valid = bus.dout_valid;
      mon_prev_ready = bus.dout_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start      = 1'b0;
    bus.serin      = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    bus.clr_ovr    = 1'b0;

    // Reset state
    #9;
    check("rst_data",    bus.Data_out, '0);
    check("rst_valid",   N'(bus.dout_valid), '0);
    check("rst_busy",    N'(bus.busy), '0);
    check("rst_overrun", N'(bus.overrun), '0);
    check("rst_state",   N'(bus.dbg_state), N'(ST_IDLE));
    #1 reset = 1'b0;
    tick();

    // Frame 1: single bit 32, consumer not ready
    exp_q.push_back(64'h0000_0001_0000_0000);
    send_start(1'b0, 1'b0);
    check("f1_busy_start", N'(bus.busy), N'(1));
    send_bits(64'd4294967296, 64, 1'b0, 1'b0);
    check("f1_data",  bus.Data_out, 64'h0000_0001_0000_0000);
    check("f1_valid", N'(bus.dout_valid), N'(1));
    tick();
    check("f1_busy_after", N'(bus.busy), '0);

    // Frame 2: all ones, consumer drains in the completion cycle
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    send_start(1'b0, 1'b0);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 1'b1);
    check("f2_data",    bus.Data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("f2_valid",   N'(bus.dout_valid), N'(1));
    check("f2_overrun", N'(bus.overrun), '0);

    // Frame 3: buffer full, no drain -> dropped with overrun
    send_start(1'b0, 1'b0);
    send_bits(64'hA5A5_A5A5_A5A5_A5A5, 64, 1'b0, 1'b0);
    check("f3_data_kept", bus.Data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("f3_overrun",   N'(bus.overrun), N'(1));
    repeat (5) tick();
    check("f3_hold_data",    bus.Data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("f3_hold_overrun", N'(bus.overrun), N'(1));
    check("f3_hold_valid",   N'(bus.dout_valid), N'(1));
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("f3_ovr_cleared", N'(bus.overrun), '0);
    drain();
    check("f3_drained_valid", N'(bus.dout_valid), '0);

    // Abort and restart: 20 ones, restart with a same-cycle strobe, then 64'h1
    send_start(1'b0, 1'b0);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20, 1'b0, 1'b0);
    check("ab_busy_mid", N'(bus.busy), N'(1));
    exp_q.push_back(64'h1);
    send_start(1'b1, 1'b1);
    send_bits(64'h1, 63, 1'b0, 1'b0);
    check("ab_no_early_valid", N'(bus.dout_valid), '0);
    check("ab_busy_63",        N'(bus.busy), N'(1));
    bus.ser_valid = 1'b1;
    bus.serin     = 1'b0;
    tick();
    bus.ser_valid = 1'b0;
    check("ab_valid", N'(bus.dout_valid), N'(1));
    check("ab_data",  bus.Data_out, 64'h1);
    check("ab_busy_done", N'(bus.busy), '0);
    drain();

    // Mid-frame reset
    send_start(1'b0, 1'b0);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 30, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("mr_data",    bus.Data_out, '0);
    check("mr_valid",   N'(bus.dout_valid), '0);
    check("mr_busy",    N'(bus.busy), '0);
    check("mr_overrun", N'(bus.overrun), '0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_valid_after", N'(bus.dout_valid), '0);
    check("mr_busy_after",  N'(bus.busy), '0);

    // Gapped strobes
    exp_q.push_back(64'h8000_0000_0000_0001);
    send_start(1'b0, 1'b0);
    send_bits(64'h8000_0000_0000_0001, 64, 1'b1, 1'b0);
    check("gap_data",  bus.Data_out, 64'h8000_0000_0000_0001);
    check("gap_valid", N'(bus.dout_valid), N'(1));
    drain();
    repeat (3) tick();

    check("queue_empty", N'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
